// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage: splits a single-ended PWM into high/low
// drives with programmable dead time on every edge and no overlap.
module pwm_deadtime #(
    parameter int DT_WIDTH   = 8,
    parameter bit H_ACT_HIGH = 1'b1,
    parameter bit L_ACT_HIGH = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_rise,
    input  logic [DT_WIDTH-1:0] dead_fall,
    output logic                pwm_h,
    output logic                pwm_l,
    output logic                in_dead,
    output logic                swallowed
);

    // state     | meaning
    // ----------+--------------------------------------------------
    // S_OFF     | disabled or just reset, both drives inactive
    // S_LOW     | low side on, high side off
    // S_DT_RISE | both off, waiting to turn the high side on
    // S_HIGH    | high side on, low side off
    // S_DT_FALL | both off, waiting to turn the low side on
    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_LOW     = 3'd1,
        S_DT_RISE = 3'd2,
        S_HIGH    = 3'd3,
        S_DT_FALL = 3'd4
    } state_t;

    localparam logic H_INV = logic'(!H_ACT_HIGH);
    localparam logic L_INV = logic'(!L_ACT_HIGH);

    state_t              state, state_nxt;
    logic [DT_WIDTH-1:0] cnt, cnt_nxt;
    logic                swallow_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_OFF;
            cnt       <= '0;
            pwm_h     <= H_INV;
            pwm_l     <= L_INV;
            in_dead   <= 1'b0;
            swallowed <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pwm_h     <= (state_nxt == S_HIGH) ^ H_INV;
            pwm_l     <= (state_nxt == S_LOW) ^ L_INV;
            in_dead   <= (state_nxt == S_DT_RISE) || (state_nxt == S_DT_FALL);
            swallowed <= swallow_nxt;
        end
    end

    // A dead time of N is realised as N cycles in a DT state, so the counter
    // is loaded with N-1 and the exit happens on the edge that sees zero.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        swallow_nxt = 1'b0;
        if (!en) begin
            state_nxt = S_OFF;
            cnt_nxt   = '0;
        end else begin
            case (state)
                S_OFF, S_LOW: begin
                    if (pwm_in) begin
                        if (dead_rise == '0) begin
                            state_nxt = S_HIGH;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = S_DT_RISE;
                            cnt_nxt   = dead_rise - DT_WIDTH'(1);
                        end
                    end else if (state == S_OFF) begin
                        if (dead_fall == '0) begin
                            state_nxt = S_LOW;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = S_DT_FALL;
                            cnt_nxt   = dead_fall - DT_WIDTH'(1);
                        end
                    end
                end
                S_HIGH: begin
                    if (!pwm_in) begin
                        if (dead_fall == '0) begin
                            state_nxt = S_LOW;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = S_DT_FALL;
                            cnt_nxt   = dead_fall - DT_WIDTH'(1);
                        end
                    end
                end
                S_DT_RISE: begin
                    if (!pwm_in) begin
                        state_nxt   = S_LOW;
                        cnt_nxt     = '0;
                        swallow_nxt = 1'b1;
                    end else if (cnt == '0) begin
                        state_nxt = S_HIGH;
                    end else begin
                        cnt_nxt = cnt - DT_WIDTH'(1);
                    end
                end
                S_DT_FALL: begin
                    if (pwm_in) begin
                        state_nxt   = S_HIGH;
                        cnt_nxt     = '0;
                        swallow_nxt = 1'b1;
                    end else if (cnt == '0) begin
                        state_nxt = S_LOW;
                    end else begin
                        cnt_nxt = cnt - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_nxt = S_OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Bench for pwm_deadtime: an active-high and an active-low instance share
// stimulus and are both compared against a cycle-level dead-time model.
module tb_pwm_deadtime;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       pwm_in;
    logic [7:0] dead_rise;
    logic [7:0] dead_fall;
    logic       h_a, l_a, dead_a, swal_a;
    logic       h_b, l_b, dead_b, swal_b;

    int errors = 0;
    int checks = 0;

    // model: m_on 0=none 1=low 2=high; m_dead = dead cycles still to show
    int   m_on, m_dead, m_target;
    logic m_swal;

    always #5 clk = ~clk;

    pwm_deadtime #(.DT_WIDTH(8), .H_ACT_HIGH(1'b1), .L_ACT_HIGH(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
        .dead_rise(dead_rise), .dead_fall(dead_fall),
        .pwm_h(h_a), .pwm_l(l_a), .in_dead(dead_a), .swallowed(swal_a)
    );

    pwm_deadtime #(.DT_WIDTH(8), .H_ACT_HIGH(1'b0), .L_ACT_HIGH(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .pwm_in(pwm_in),
        .dead_rise(dead_rise), .dead_fall(dead_fall),
        .pwm_h(h_b), .pwm_l(l_b), .in_dead(dead_b), .swallowed(swal_b)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_on = 0; m_dead = 0; m_target = 0; m_swal = 1'b0;
    endtask

    task automatic model_edge();
        int want;
        m_swal = 1'b0;
        want   = pwm_in ? 2 : 1;
        if (!en) begin
            m_on = 0; m_dead = 0;
        end else if (m_dead > 0) begin
            if (want != m_target) begin
                m_on = want; m_dead = 0; m_swal = 1'b1;
            end else begin
                m_dead--;
                if (m_dead == 0) m_on = m_target;
            end
        end else if (m_on != want) begin
            m_target = want;
            m_dead   = (want == 2) ? int'(dead_rise) : int'(dead_fall);
            m_on     = (m_dead == 0) ? want : 0;
        end
    endtask

    task automatic check_all();
        logic eh, el;
        eh = (m_on == 2);
        el = (m_on == 1);
        chk("h_a",    h_a,    eh);
        chk("l_a",    l_a,    el);
        chk("dead_a", dead_a, m_dead > 0);
        chk("swal_a", swal_a, m_swal);
        chk("h_b",    h_b,    ~eh);
        chk("l_b",    l_b,    ~el);
        chk("dead_b", dead_b, m_dead > 0);
        chk("swal_b", swal_b, m_swal);
        chk("overlap_a", h_a & l_a, 1'b0);
        chk("overlap_b", (~h_b) & (~l_b), 1'b0);
    endtask

    // inputs are set between a negedge and the next posedge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int n_dead, n_swal, n_h;
        rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0; dead_rise = 8'd0; dead_fall = 8'd0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // enable into low side with dead_fall=3
        en = 1'b1; pwm_in = 1'b0; dead_fall = 8'd3;
        n_dead = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (dead_a) n_dead++;
        end
        chk("s1_dead_cycles", n_dead == 3, 1'b1);

        // rise with dead_rise=4, fall with dead_fall=2
        dead_rise = 8'd4; pwm_in = 1'b1;
        for (int i = 0; i < 6; i++) step();
        dead_fall = 8'd2; pwm_in = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // zero dead time, toggle every cycle
        dead_rise = 8'd0; dead_fall = 8'd0;
        for (int i = 0; i < 10; i++) begin
            pwm_in = ~pwm_in;
            step();
        end
        pwm_in = 1'b0;
        step();

        // short pulse swallowed
        dead_rise = 8'd5; n_swal = 0; n_h = 0;
        pwm_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_swal += int'(swal_a); n_h += int'(h_a);
        end
        pwm_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_swal += int'(swal_a); n_h += int'(h_a);
        end
        chk("s4_one_swallow", n_swal == 1, 1'b1);
        chk("s4_h_never", n_h == 0, 1'b1);
        chk("s4_l_back", l_a, 1'b1);

        // HIGH, drop en, re-enable with dead_rise=2, reset mid dead time
        dead_rise = 8'd0; pwm_in = 1'b1;
        step(); step();
        en = 1'b0;
        step();
        en = 1'b1; dead_rise = 8'd2;
        for (int i = 0; i < 4; i++) step();
        pwm_in = 1'b0; dead_fall = 8'd6;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(3, 0) == 0) pwm_in = ~pwm_in;
            if ($urandom_range(15, 0) == 0) dead_rise = 8'($urandom_range(5, 0));
            if ($urandom_range(15, 0) == 0) dead_fall = 8'($urandom_range(5, 0));
            en = ($urandom_range(49, 0) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
